// File: rtl/b2s_bresp_collector.sv
// b2s_bresp_collector
//   Drains one command entry (ID + beat count minus one) per AXI write,
//   accepts that many MI-side B responses, then issues a single S-side B
//   response carrying the entry's ID.
//   Optional build macro: B2S_BRESP_MERGE_EN
//     defined   -> response codes of all beats are merged (DECERR > SLVERR >
//                  all-EXOKAY > OKAY)
//     undefined -> the final beat's response code is forwarded unchanged
module b2s_bresp_collector #(
   parameter int C_ID_WIDTH  = 4,
   parameter int C_CNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_empty,
   input  logic [C_ID_WIDTH-1:0]  cmd_id,
   input  logic [C_CNT_WIDTH-1:0] cmd_cnt,
   output logic                   cmd_rd_en,
   input  logic                   m_bvalid,
   input  logic [1:0]             m_bresp,
   output logic                   m_bready,
   output logic                   s_bvalid,
   output logic [C_ID_WIDTH-1:0]  s_bid,
   output logic [1:0]             s_bresp,
   input  logic                   s_bready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESP    = 2'd2
   } state_t;

   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state_q;
   state_t                   state_d;
   logic [C_ID_WIDTH-1:0]    id_q;
   logic [C_CNT_WIDTH-1:0]   rem_q;
   logic                     m_hs;
   logic                     s_hs;
   logic                     last_beat;
   logic [1:0]               resp_code;

   // Handshake decode; FIFO pop is gated by rst so nothing is popped while in reset
   always_comb begin
      cmd_rd_en = (state_q == IDLE) && !cmd_empty && !rst;
      m_bready  = (state_q == COLLECT);
      s_bvalid  = (state_q == RESP);
      m_hs      = m_bvalid && m_bready;
      s_hs      = s_bvalid && s_bready;
      last_beat = (rem_q == '0);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_rd_en) state_d = COLLECT;
         end
         COLLECT: begin
            if (m_hs && last_beat) state_d = RESP;
         end
         RESP: begin
            if (s_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ID capture and remaining-beat counter (counts down to zero, never wraps)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q  <= '0;
         rem_q <= '0;
      end else if (cmd_rd_en) begin
         id_q  <= cmd_id;
         rem_q <= cmd_cnt;
      end else if (m_hs && !last_beat) begin
         rem_q <= rem_q - CNT_ONE;
      end
   end

`ifdef B2S_BRESP_MERGE_EN
   logic any_decerr_q;
   logic any_slverr_q;
   logic all_exokay_q;

   // Merge accumulator: sticky error flags plus an all-exclusive flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_decerr_q <= 1'b0;
         any_slverr_q <= 1'b0;
         all_exokay_q <= 1'b0;
      end else if (cmd_rd_en) begin
         any_decerr_q <= 1'b0;
         any_slverr_q <= 1'b0;
         all_exokay_q <= 1'b1;
      end else if (m_hs) begin
         any_decerr_q <= any_decerr_q || (m_bresp == 2'b11);
         any_slverr_q <= any_slverr_q || (m_bresp == 2'b10);
         all_exokay_q <= all_exokay_q && (m_bresp == 2'b01);
      end
   end

   // Priority encode the merged response
   always_comb begin
      resp_code = 2'b00;
      if (any_decerr_q)      resp_code = 2'b11;
      else if (any_slverr_q) resp_code = 2'b10;
      else if (all_exokay_q) resp_code = 2'b01;
   end
`else
   logic [1:0] last_resp_q;

   // Keep only the most recent beat's response; the final beat wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_resp_q <= 2'b00;
      end else if (m_hs) begin
         last_resp_q <= m_bresp;
      end
   end

   // Forward the final beat's response
   always_comb begin
      resp_code = last_resp_q;
   end
`endif

   // S-side payload is driven only while the response is being offered
   always_comb begin
      s_bid   = s_bvalid ? id_q : '0;
      s_bresp = s_bvalid ? resp_code : 2'b00;
   end

endmodule

// File: tb/tb_b2s_bresp_collector.sv
// Directed bench for b2s_bresp_collector (count field 3 bits wide so the
// maximum-count case is 8 beats). Expectations follow B2S_BRESP_MERGE_EN.
module tb_b2s_bresp_collector;

`ifdef B2S_BRESP_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_empty;
   logic [3:0] cmd_id;
   logic [2:0] cmd_cnt;
   logic       cmd_rd_en;
   logic       m_bvalid;
   logic [1:0] m_bresp;
   logic       m_bready;
   logic       s_bvalid;
   logic [3:0] s_bid;
   logic [1:0] s_bresp;
   logic       s_bready;

   int vecs = 0;
   int errs = 0;

   // Command FIFO model
   logic [3:0]  fid  [16];
   logic [2:0]  fcnt [16];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   int unsigned m_hs_cnt = 0;
   int unsigned s_hs_cnt = 0;
   int unsigned pop_cnt  = 0;

   assign cmd_empty = (rd_ptr == wr_ptr);
   assign cmd_id    = fid[rd_ptr % 16];
   assign cmd_cnt   = fcnt[rd_ptr % 16];

   always #5 clk = ~clk;

   b2s_bresp_collector #(
      .C_ID_WIDTH (4),
      .C_CNT_WIDTH(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_empty(cmd_empty),
      .cmd_id   (cmd_id),
      .cmd_cnt  (cmd_cnt),
      .cmd_rd_en(cmd_rd_en),
      .m_bvalid (m_bvalid),
      .m_bresp  (m_bresp),
      .m_bready (m_bready),
      .s_bvalid (s_bvalid),
      .s_bid    (s_bid),
      .s_bresp  (s_bresp),
      .s_bready (s_bready)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) rd_ptr <= wr_ptr;
      else if (cmd_rd_en) rd_ptr <= rd_ptr + 1;
   end

   always @(posedge clk) begin
      if (m_bvalid && m_bready) m_hs_cnt <= m_hs_cnt + 1;
      if (s_bvalid && s_bready) s_hs_cnt <= s_hs_cnt + 1;
      if (cmd_rd_en)            pop_cnt  <= pop_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] id, input logic [2:0] cnt);
      fid[wr_ptr % 16]  = id;
      fcnt[wr_ptr % 16] = cnt;
      wr_ptr++;
   endtask

   // One full transaction with s_bready held high; beat k uses resps[2k+:2]
   task automatic txn(input string tag, input logic [3:0] id, input logic [2:0] cnt,
                      input logic [15:0] resps, input bit gaps, input logic [1:0] exp);
      int unsigned mh0;
      int unsigned beat;
      int to;
      mh0 = m_hs_cnt;
      s_bready = 1'b1;
      push(id, cnt);
      to = 0;
      beat = 0;
      while (!s_bvalid && to < 200) begin
         m_bresp  = resps[2*beat +: 2];
         m_bvalid = (beat <= cnt) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
         tick();
         beat = m_hs_cnt - mh0;
         to++;
      end
      m_bvalid = 1'b0;
      chk({tag, "_timeout"}, (to < 200), 1);
      chk({tag, "_bid"},     s_bid, id);
      chk({tag, "_bresp"},   s_bresp, exp);
      chk({tag, "_beats"},   m_hs_cnt - mh0, cnt + 1);
      tick();
      chk({tag, "_done"},    s_bvalid, 0);
   endtask

   initial begin
      int unsigned mh0;
      int unsigned sh0;
      int to;

      rst = 1'b1;
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      s_bready = 1'b1;
      tick();
      tick();
      chk("rst_rd_en",  cmd_rd_en, 0);
      chk("rst_bready", m_bready, 0);
      chk("rst_bvalid", s_bvalid, 0);
      chk("rst_bid",    s_bid, 0);
      chk("rst_bresp",  s_bresp, 0);
      rst = 1'b0;
      tick();

      // Single beat: pop cycle T0, COLLECT in T1, s_bvalid in T2
      push(4'd3, 3'd0);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      #1;
      chk("t1_pop", cmd_rd_en, 1);
      tick();
      chk("t1_pop_once", cmd_rd_en, 0);
      chk("t1_mready",   m_bready, 1);
      chk("t1_no_sv",    s_bvalid, 0);
      tick();
      m_bvalid = 1'b0;
      chk("t1_sv",      s_bvalid, 1);
      chk("t1_bid",     s_bid, 3);
      chk("t1_bresp",   s_bresp, 0);
      chk("t1_mready0", m_bready, 0);
      tick();
      chk("t1_idle",  s_bvalid, 0);
      chk("t1_pops",  pop_cnt, 1);
      chk("t1_shs",   s_hs_cnt, 1);

      // Four beats, SLVERR on beat 1
      sh0 = s_hs_cnt;
      txn("four", 4'd5, 3'd3, 16'h0008, 1'b0, MERGE ? 2'b10 : 2'b00);
      chk("four_one_resp", s_hs_cnt - sh0, 1);

      txn("exex",   4'd6, 3'd1, 16'h0005, 1'b0, 2'b01);
      txn("exok",   4'd7, 3'd1, 16'h0001, 1'b0, 2'b00);
      txn("slvdec", 4'd8, 3'd1, 16'h000E, 1'b0, 2'b11);
      txn("decok",  4'd9, 3'd1, 16'h0003, 1'b1, MERGE ? 2'b11 : 2'b00);

      // Backpressure with two queued entries
      s_bready = 1'b0;
      push(4'd1, 3'd0);
      push(4'd2, 3'd1);
      m_bvalid = 1'b1;
      m_bresp  = 2'b10;
      to = 0;
      while (!s_bvalid && to < 50) begin
         tick();
         to++;
      end
      chk("bp_timeout", (to < 50), 1);
      mh0 = m_hs_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_sv",     s_bvalid, 1);
         chk("bp_bid",    s_bid, 1);
         chk("bp_bresp",  s_bresp, 2'b10);
         chk("bp_mready", m_bready, 0);
         chk("bp_rd_en",  cmd_rd_en, 0);
      end
      chk("bp_no_mhs", m_hs_cnt - mh0, 0);
      s_bready = 1'b1;
      tick();
      m_bresp = 2'b01;
      chk("bp_next_pop", cmd_rd_en, 1);
      chk("bp_sv_drop",  s_bvalid, 0);
      to = 0;
      while (!s_bvalid && to < 50) begin
         tick();
         to++;
      end
      m_bvalid = 1'b0;
      chk("bp2_timeout", (to < 50), 1);
      chk("bp2_bid",     s_bid, 2);
      chk("bp2_bresp",   s_bresp, 2'b01);
      tick();

      // Reset in the middle of collecting 4 beats
      sh0 = s_hs_cnt;
      mh0 = m_hs_cnt;
      push(4'd10, 3'd3);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      to = 0;
      while ((m_hs_cnt - mh0) < 2 && to < 50) begin
         tick();
         to++;
      end
      chk("rm_timeout", (to < 50), 1);
      chk("rm_mready",  m_bready, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("rm_mready0", m_bready, 0);
      chk("rm_sv0",     s_bvalid, 0);
      chk("rm_rd_en0",  cmd_rd_en, 0);
      m_bvalid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rm_no_sv", s_bvalid, 0);
      end
      chk("rm_no_shs", s_hs_cnt - sh0, 0);
      txn("rm_after", 4'd11, 3'd0, 16'h0000, 1'b0, 2'b00);

      // Maximum count: 8 beats, DECERR on the first, gapped valids
      sh0 = s_hs_cnt;
      txn("max", 4'd12, 3'd7, 16'h0003, 1'b1, MERGE ? 2'b11 : 2'b00);
      chk("max_one_resp", s_hs_cnt - sh0, 1);
      tick();
      chk("max_idle", m_bready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
